// File: rtl/step_pulse_gen_pkg.sv
// Shared definitions for the STEP/DIR pulse generator: register map,
// register bit positions, FSM state encoding and status word packing.
package step_pulse_gen_pkg;

  // Word offsets of the four bus-visible registers
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_DIR_BIT   = 2;

  // STATUS bit positions
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_ABORT_BIT = 2;
  localparam int STAT_REM_LSB   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } step_state_e;

  // Assemble the 32-bit STATUS word from its individual fields
  function automatic logic [31:0] pack_status(input logic        busy,
                                              input logic        done,
                                              input logic        aborted,
                                              input logic [15:0] remaining);
    logic [31:0] word;
    word = '0;
    word[STAT_BUSY_BIT]  = busy;
    word[STAT_DONE_BIT]  = done;
    word[STAT_ABORT_BIT] = aborted;
    word[STAT_REM_LSB +: 16] = remaining;
    return word;
  endfunction

endpackage

// File: rtl/step_pulse_gen_timer.sv
// Loadable down-counter with a zero flag. A phase lasting N cycles is
// timed by loading N-1; the owner acts on the edge where zero is seen.
module step_pulse_gen_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority; otherwise count down and rest at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// Memory-mapped STEP/DIR pulse generator for one stepper axis.
// Holds the bus register file and the move sequencer; a shared down-counter
// times the direction setup, STEP high and STEP low phases.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PULSE_WIDTH = 50,
  parameter int DIR_SETUP   = 25,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  enable,
  input  logic                  write,
  input  logic [1:0]            addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  step_out,
  output logic                  dir_out,
  output logic                  busy_out
);

  localparam logic [COUNT_WIDTH-1:0] PW_C       = COUNT_WIDTH'(PULSE_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] MIN_PERIOD = COUNT_WIDTH'(2 * PULSE_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] SETUP_LOAD = COUNT_WIDTH'(DIR_SETUP - 1);
  localparam logic [COUNT_WIDTH-1:0] HIGH_LOAD  = COUNT_WIDTH'(PULSE_WIDTH - 1);

  // Bus handshake and read data
  logic                   ready_q, ready_d;
  logic                   ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  // Programmed registers
  logic                   ctrl_dir_q, ctrl_dir_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // Move state latched at START
  logic [COUNT_WIDTH-1:0] eff_q, eff_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  step_state_e            state_q, state_d;
  logic                   step_q, step_d;
  logic                   dir_q, dir_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;

  // Phase timer interface
  logic                   timer_load;
  logic [COUNT_WIDTH-1:0] timer_val;
  logic                   timer_zero;

  // Decoded write strobes, one per committed access
  logic wr_fire;
  logic ctrl_wr;
  logic start_req;
  logic abort_req;

  assign wr_fire   = enable & write & ready_q & ~ack_q;
  assign ctrl_wr   = wr_fire && (addr_in == ADDR_CTRL);
  assign abort_req = ctrl_wr & data_in[CTRL_ABORT_BIT];
  assign start_req = ctrl_wr & data_in[CTRL_START_BIT] & ~data_in[CTRL_ABORT_BIT];

  step_pulse_gen_timer #(
    .WIDTH (COUNT_WIDTH)
  ) u_timer (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Next-state for bus handshake, register file and move sequencer
  always_comb begin
    ready_d     = enable;
    ack_d       = enable & ready_q;
    rdata_d     = '0;
    ctrl_dir_d  = ctrl_dir_q;
    period_d    = period_q;
    count_d     = count_q;
    eff_d       = eff_q;
    remaining_d = remaining_q;
    state_d     = state_q;
    step_d      = step_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    timer_load  = 1'b0;
    timer_val   = '0;

    // Read data is captured every cycle; only the value under ready matters
    case (addr_in)
      ADDR_CTRL:   rdata_d[CTRL_DIR_BIT] = ctrl_dir_q;
      ADDR_PERIOD: rdata_d = DATA_WIDTH'(period_q);
      ADDR_COUNT:  rdata_d = DATA_WIDTH'(count_q);
      default:     rdata_d = DATA_WIDTH'(pack_status(busy_q, done_q, aborted_q,
                                                     remaining_q[15:0]));
    endcase

    // Register writes; START/ABORT are strobes and are not stored
    if (wr_fire) begin
      case (addr_in)
        ADDR_CTRL:   ctrl_dir_d = data_in[CTRL_DIR_BIT];
        ADDR_PERIOD: period_d   = data_in[COUNT_WIDTH-1:0];
        ADDR_COUNT:  count_d    = data_in[COUNT_WIDTH-1:0];
        default: begin
          if (data_in[STAT_DONE_BIT])  done_d    = 1'b0;
          if (data_in[STAT_ABORT_BIT]) aborted_d = 1'b0;
        end
      endcase
    end

    // Move sequencer; ABORT overrides any active phase
    if (state_q != ST_IDLE && abort_req) begin
      step_d    = 1'b0;
      busy_d    = 1'b0;
      aborted_d = 1'b1;
      state_d   = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            if (count_q == '0) begin
              done_d = 1'b1;
            end else begin
              // The START write may carry the new direction itself
              dir_d       = ctrl_dir_d;
              eff_d       = (period_q < MIN_PERIOD) ? MIN_PERIOD : period_q;
              remaining_d = count_q;
              done_d      = 1'b0;
              aborted_d   = 1'b0;
              busy_d      = 1'b1;
              timer_load  = 1'b1;
              timer_val   = SETUP_LOAD;
              state_d     = ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (timer_zero) begin
            step_d      = 1'b1;
            remaining_d = remaining_q - COUNT_WIDTH'(1);
            timer_load  = 1'b1;
            timer_val   = HIGH_LOAD;
            state_d     = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (timer_zero) begin
            step_d     = 1'b0;
            timer_load = 1'b1;
            timer_val  = eff_q - PW_C - COUNT_WIDTH'(1);
            state_d    = ST_LOW;
          end
        end
        default: begin
          if (timer_zero) begin
            if (remaining_q != '0) begin
              step_d      = 1'b1;
              remaining_d = remaining_q - COUNT_WIDTH'(1);
              timer_load  = 1'b1;
              timer_val   = HIGH_LOAD;
              state_d     = ST_HIGH;
            end else begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  // All state registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ready_q     <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      ctrl_dir_q  <= 1'b0;
      period_q    <= '0;
      count_q     <= '0;
      eff_q       <= '0;
      remaining_q <= '0;
      state_q     <= ST_IDLE;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      ctrl_dir_q  <= ctrl_dir_d;
      period_q    <= period_d;
      count_q     <= count_d;
      eff_q       <= eff_d;
      remaining_q <= remaining_d;
      state_q     <= state_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  // Shared read bus: release it whenever this slave is not selected
  assign data_out = enable ? rdata_q : {DATA_WIDTH{1'bz}};
  assign ready    = enable ? ready_q : 1'bz;

  assign step_out = step_q;
  assign dir_out  = dir_q;
  assign busy_out = busy_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: bus accesses, pulse timing, abort,
// ignored restart, W1C flags, mid-move reset and bus release.
module tb_step_pulse_gen;
  import step_pulse_gen_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        enable;
  logic        write;
  logic [1:0]  addr_in;
  logic [31:0] data_in;
  wire  [31:0] data_bus;
  wire         ready_bus;
  logic        step_out;
  logic        dir_out;
  logic        busy_out;

  // Second bus master used to observe that the DUT releases the shared lines
  logic        other_en = 1'b0;
  logic [31:0] other_data = 32'h0;
  assign data_bus  = other_en ? other_data : 32'hzzzz_zzzz;
  assign ready_bus = other_en ? 1'b1 : 1'bz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int commit_cyc;
  int idle_cyc;

  // STEP edge monitor
  logic mon_clr = 1'b1;
  logic prev_step;
  int   n_rise;
  int   n_fall;
  int   rise_c[16];
  int   fall_c[16];

  step_pulse_gen dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .enable   (enable),
    .write    (write),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .data_out (data_bus),
    .ready    (ready_bus),
    .step_out (step_out),
    .dir_out  (dir_out),
    .busy_out (busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Record the cycle index of every STEP rising and falling edge
  always begin
    @(posedge clk_in);
    #2;
    if (mon_clr) begin
      n_rise    = 0;
      n_fall    = 0;
      prev_step = 1'b0;
    end else begin
      if (step_out === 1'b1 && prev_step === 1'b0) begin
        if (n_rise < 16) rise_c[n_rise] = cyc;
        n_rise = n_rise + 1;
      end
      if (step_out === 1'b0 && prev_step === 1'b1) begin
        if (n_fall < 16) fall_c[n_fall] = cyc;
        n_fall = n_fall + 1;
      end
      prev_step = step_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    enable = 1'b1; write = 1'b1; addr_in = a; data_in = d;
    do begin
      @(posedge clk_in); #1; n++;
    end while (ready_bus !== 1'b1 && n < 8);
    if (ready_bus !== 1'b1) chk("wr_ready_timeout", {31'b0, ready_bus}, 32'h1);
    @(posedge clk_in); #1;
    commit_cyc = cyc;
    $display("WR  addr=%0d data=0x%08h commit_cyc=%0d", a, d, commit_cyc);
    @(negedge clk_in);
    enable = 1'b0; write = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    int n;
    n = 0;
    enable = 1'b1; write = 1'b0; addr_in = a;
    do begin
      @(posedge clk_in); #1; n++;
    end while (ready_bus !== 1'b1 && n < 8);
    if (ready_bus !== 1'b1) chk("rd_ready_timeout", {31'b0, ready_bus}, 32'h1);
    d = data_bus;
    $display("RD  addr=%0d data=0x%08h cyc=%0d", a, d, cyc);
    @(negedge clk_in);
    enable = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic clear_monitor();
    mon_clr = 1'b1;
    @(negedge clk_in);
    mon_clr = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy_out !== 1'b0 && n < limit) begin
      @(negedge clk_in); n++;
    end
    idle_cyc = cyc;
    if (busy_out !== 1'b0) chk("idle_timeout", {31'b0, busy_out}, 32'h0);
  endtask

  task automatic wait_rises(input int want, input int limit);
    int n;
    n = 0;
    while (n_rise < want && n < limit) begin
      @(negedge clk_in); n++;
    end
    if (n_rise < want) chk("rise_timeout", n_rise, want);
  endtask

  logic [31:0] rd;

  initial begin
    reset_in = 1'b1; enable = 1'b0; write = 1'b0; addr_in = 2'd0; data_in = 32'h0;

    // Reset
    repeat (2) @(negedge clk_in);
    chk("rst_step", {31'b0, step_out}, 32'h0);
    chk("rst_dir",  {31'b0, dir_out},  32'h0);
    chk("rst_busy", {31'b0, busy_out}, 32'h0);
    reset_in = 1'b0;
    @(negedge clk_in);
    clear_monitor();
    bus_read(ADDR_STATUS, rd);
    chk("rst_status", rd, 32'h0);

    // Three pulses at PERIOD=200, DIR=1
    bus_write(ADDR_PERIOD, 32'd200);
    bus_write(ADDR_COUNT, 32'd3);
    bus_read(ADDR_PERIOD, rd);
    chk("period_rb", rd, 32'd200);
    clear_monitor();
    bus_write(ADDR_CTRL, 32'h5);
    chk("m1_busy", {31'b0, busy_out}, 32'h1);
    chk("m1_dir",  {31'b0, dir_out},  32'h1);
    wait_idle(2000);
    chk("m1_nrise", n_rise, 3);
    chk("m1_first_rise", rise_c[0] - commit_cyc, 25);
    chk("m1_space01", rise_c[1] - rise_c[0], 200);
    chk("m1_space12", rise_c[2] - rise_c[1], 200);
    chk("m1_high0", fall_c[0] - rise_c[0], 50);
    chk("m1_high2", fall_c[2] - rise_c[2], 50);
    chk("m1_done_time", idle_cyc - commit_cyc, 625);
    bus_read(ADDR_STATUS, rd);
    chk("m1_status", rd, 32'h2);

    // PERIOD below the minimum is stretched to 2*PULSE_WIDTH
    bus_write(ADDR_PERIOD, 32'd10);
    bus_write(ADDR_COUNT, 32'd2);
    clear_monitor();
    bus_write(ADDR_CTRL, 32'h5);
    wait_idle(2000);
    chk("m2_nrise", n_rise, 2);
    chk("m2_space", rise_c[1] - rise_c[0], 100);
    chk("m2_high", fall_c[1] - rise_c[1], 50);
    chk("m2_done_time", idle_cyc - commit_cyc, 225);

    // W1C of done, then START with COUNT=0
    bus_write(ADDR_STATUS, 32'h2);
    bus_read(ADDR_STATUS, rd);
    chk("w1c_done", rd, 32'h0);
    bus_write(ADDR_COUNT, 32'd0);
    clear_monitor();
    bus_write(ADDR_CTRL, 32'h5);
    chk("cnt0_busy", {31'b0, busy_out}, 32'h0);
    bus_read(ADDR_STATUS, rd);
    chk("cnt0_status", rd, 32'h2);
    repeat (40) @(negedge clk_in);
    chk("cnt0_nrise", n_rise, 0);

    // ABORT 20 cycles into the second HIGH of a 5-step move
    bus_write(ADDR_PERIOD, 32'd200);
    bus_write(ADDR_COUNT, 32'd5);
    clear_monitor();
    bus_write(ADDR_CTRL, 32'h5);
    wait_rises(2, 1000);
    repeat (18) @(negedge clk_in);
    bus_write(ADDR_CTRL, 32'h2);
    chk("ab_fall_at_commit", fall_c[1], commit_cyc);
    chk("ab_high_len", fall_c[1] - rise_c[1], 20);
    chk("ab_busy", {31'b0, busy_out}, 32'h0);
    bus_read(ADDR_STATUS, rd);
    chk("ab_status", rd, 32'h0003_0004);
    repeat (300) @(negedge clk_in);
    chk("ab_nrise", n_rise, 2);
    bus_write(ADDR_STATUS, 32'h4);
    bus_read(ADDR_STATUS, rd);
    chk("w1c_abort", rd, 32'h0003_0000);

    // START with DIR=0 during a move is ignored
    bus_write(ADDR_COUNT, 32'd2);
    clear_monitor();
    bus_write(ADDR_CTRL, 32'h5);
    idle_cyc = commit_cyc;
    repeat (40) @(negedge clk_in);
    bus_write(ADDR_CTRL, 32'h1);
    chk("busy_start_dir", {31'b0, dir_out}, 32'h1);
    commit_cyc = idle_cyc;
    wait_idle(2000);
    chk("busy_start_nrise", n_rise, 2);
    chk("busy_start_time", idle_cyc - commit_cyc, 425);
    bus_read(ADDR_STATUS, rd);
    chk("busy_start_status", rd, 32'h2);
    bus_read(ADDR_CTRL, rd);
    chk("ctrl_rb_dir", rd, 32'h0);
    bus_write(ADDR_STATUS, 32'h2);
    bus_read(ADDR_STATUS, rd);
    chk("w1c_done2", rd, 32'h0);

    // Reset asserted in the middle of a HIGH phase
    bus_write(ADDR_COUNT, 32'd4);
    clear_monitor();
    bus_write(ADDR_CTRL, 32'h5);
    wait_rises(1, 1000);
    repeat (10) @(negedge clk_in);
    chk("pre_rst_step", {31'b0, step_out}, 32'h1);
    reset_in = 1'b1;
    @(negedge clk_in);
    chk("mid_rst_step", {31'b0, step_out}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy_out}, 32'h0);
    chk("mid_rst_dir",  {31'b0, dir_out},  32'h0);
    reset_in = 1'b0;
    @(negedge clk_in);
    bus_read(ADDR_STATUS, rd);
    chk("post_rst_status", rd, 32'h0);
    bus_read(ADDR_COUNT, rd);
    chk("post_rst_count", rd, 32'h0);
    repeat (100) @(negedge clk_in);
    chk("post_rst_nrise", n_rise, 1);

    // Unselected slave leaves the shared data/ready lines to another driver
    other_data = 32'hA5A5_5A5A;
    other_en   = 1'b1;
    #1;
    chk("release_data", data_bus, 32'hA5A5_5A5A);
    chk("release_ready", {31'b0, ready_bus}, 32'h1);
    other_en = 1'b0;
    @(negedge clk_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
